// File: rtl/meter_pkg.sv
// Shared types and constants for the parking meter time-keeping slice.
package meter_pkg;

    localparam int COUNT_W = 14;
    localparam int BCD_W   = 16;
    localparam int DD_W    = BCD_W + COUNT_W;

    localparam logic [COUNT_W-1:0] MAX_COUNT  = 14'd9999;
    localparam logic [COUNT_W-1:0] ADD_U      = 14'd60;
    localparam logic [COUNT_W-1:0] ADD_L      = 14'd120;
    localparam logic [COUNT_W-1:0] ADD_R      = 14'd180;
    localparam logic [COUNT_W-1:0] ADD_D      = 14'd300;
    localparam logic [COUNT_W-1:0] PRESET_A   = 14'd10;
    localparam logic [COUNT_W-1:0] PRESET_B   = 14'd205;
    localparam logic [COUNT_W-1:0] LOW_THRESH = 14'd200;

    typedef enum logic [1:0] {
        ST_EXPIRED = 2'd0,
        ST_LOW     = 2'd1,
        ST_HIGH    = 2'd2
    } meter_state_e;

    typedef enum logic [1:0] {
        CV_IDLE  = 2'd0,
        CV_SHIFT = 2'd1,
        CV_LOAD  = 2'd2
    } conv_state_e;

    typedef logic [3:0] bcd_digit_t;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [DD_W-1:0] dabble_step(input logic [DD_W-1:0] v);
        logic [DD_W-1:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[COUNT_W+4*i +: 4] >= 4'd5)
                r[COUNT_W+4*i +: 4] = r[COUNT_W+4*i +: 4] + 4'd3;
        end
        return {r[DD_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double-dabble, one shift per cycle).
// A start pulse in any state (re)loads the operand, so a stale conversion is simply abandoned.
module bin2bcd_seq
    import meter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd,
    output conv_state_e        dbg_state
);

    conv_state_e     state_q, state_nxt;
    logic [DD_W-1:0] sh_q;
    logic [3:0]      step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CV_IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            CV_IDLE:  if (start) state_nxt = CV_SHIFT;
            CV_SHIFT: begin
                if (start)                                state_nxt = CV_SHIFT;
                else if (step_q == 4'(COUNT_W - 1))       state_nxt = CV_LOAD;
            end
            CV_LOAD:  state_nxt = start ? CV_SHIFT : CV_IDLE;
            default:  state_nxt = CV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            step_q <= '0;
        end else if (start) begin
            sh_q   <= {{BCD_W{1'b0}}, bin};
            step_q <= '0;
        end else if (state_q == CV_SHIFT) begin
            sh_q   <= dabble_step(sh_q);
            step_q <= step_q + 4'd1;
        end
    end

    // In LOAD the BCD half of the shift register holds the finished result.
    assign busy      = (state_q != CV_IDLE);
    assign done      = (state_q == CV_LOAD);
    assign bcd       = sh_q[DD_W-1 -: BCD_W];
    assign dbg_state = state_q;

endmodule

// File: rtl/meter_sequencer.sv
// Parking meter time-keeping: event arbitration, remaining-time count, state/blink and BCD display.
// Optional expiry pulse on ALARM when METER_ALARM_EN is defined.
module meter_sequencer
    import meter_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       TICK,
    input  logic       HALF_TICK,
    input  logic       BTN_U,
    input  logic       BTN_L,
    input  logic       BTN_R,
    input  logic       BTN_D,
    input  logic       PRE_A,
    input  logic       PRE_B,
    output logic [3:0] DIG0,
    output logic [3:0] DIG1,
    output logic [3:0] DIG2,
    output logic [3:0] DIG3,
    output logic       DISP_ON,
`ifdef METER_ALARM_EN
    output logic       ALARM,
`endif
    output logic [1:0] STATE
);

    logic [COUNT_W-1:0] count_q, count_nxt, add_val;
    logic [COUNT_W:0]   sum;
    logic               tick_pend_q, tick_pend_nxt;
    logic               any_btn, do_tick, conv_start_q;
    meter_state_e       state_q, state_dec;
    logic               blink_q, blink_nxt, disp_q, disp_nxt;
    bcd_digit_t         dig_q [4];
    logic               conv_busy, conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    conv_state_e        conv_state;
    logic               unused_conv;

    // Arbitration: PRE_B > PRE_A > U > L > R > D > tick (live or pending).
    always_comb begin
        add_val = '0;
        if (BTN_U)      add_val = ADD_U;
        else if (BTN_L) add_val = ADD_L;
        else if (BTN_R) add_val = ADD_R;
        else if (BTN_D) add_val = ADD_D;
        any_btn       = BTN_U | BTN_L | BTN_R | BTN_D;
        sum           = {1'b0, count_q} + {1'b0, add_val};
        do_tick       = (TICK | tick_pend_q) & ~(PRE_A | PRE_B | any_btn);
        count_nxt     = count_q;
        tick_pend_nxt = tick_pend_q;
        if (PRE_B) begin
            count_nxt     = PRESET_B;
            tick_pend_nxt = 1'b0;
        end else if (PRE_A) begin
            count_nxt     = PRESET_A;
            tick_pend_nxt = 1'b0;
        end else if (any_btn) begin
            count_nxt     = (sum > {1'b0, MAX_COUNT}) ? MAX_COUNT : sum[COUNT_W-1:0];
            tick_pend_nxt = tick_pend_q | TICK;
        end else if (do_tick) begin
            if (count_q != '0) count_nxt = count_q - 1'b1;
            // A live tick arriving alongside a pending one stays queued.
            tick_pend_nxt = TICK & tick_pend_q;
        end
    end

    always_comb begin
        if (count_q == '0)              state_dec = ST_EXPIRED;
        else if (count_q < LOW_THRESH)  state_dec = ST_LOW;
        else                            state_dec = ST_HIGH;

        if (state_dec == ST_EXPIRED && state_q != ST_EXPIRED) blink_nxt = 1'b1;
        else if (HALF_TICK)                                   blink_nxt = ~blink_q;
        else                                                  blink_nxt = blink_q;

        case (state_dec)
            ST_HIGH: disp_nxt = 1'b1;
            ST_LOW:  disp_nxt = ~count_q[0];
            default: disp_nxt = blink_nxt;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q      <= '0;
            tick_pend_q  <= 1'b0;
            conv_start_q <= 1'b0;
            state_q      <= ST_EXPIRED;
            blink_q      <= 1'b1;
            disp_q       <= 1'b1;
            dig_q        <= '{default: '0};
        end else begin
            count_q      <= count_nxt;
            tick_pend_q  <= tick_pend_nxt;
            conv_start_q <= (count_nxt != count_q);
            state_q      <= state_dec;
            blink_q      <= blink_nxt;
            disp_q       <= disp_nxt;
            if (conv_done) begin
                for (int i = 0; i < 4; i++) dig_q[i] <= conv_bcd[4*i +: 4];
            end
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .start     (conv_start_q),
        .bin       (count_q),
        .busy      (conv_busy),
        .done      (conv_done),
        .bcd       (conv_bcd),
        .dbg_state (conv_state)
    );

    assign unused_conv = conv_busy ^ (^conv_state);

`ifdef METER_ALARM_EN
    logic alarm_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) alarm_q <= 1'b0;
        else          alarm_q <= do_tick && (count_q == 14'd1);
    end

    assign ALARM = alarm_q;
`endif

    assign DIG0    = dig_q[0];
    assign DIG1    = dig_q[1];
    assign DIG2    = dig_q[2];
    assign DIG3    = dig_q[3];
    assign DISP_ON = disp_q;
    assign STATE   = state_q;

endmodule

// File: tb/tb_meter_sequencer.sv
// Directed bench for meter_sequencer with a settled-display scoreboard.
module tb_meter_sequencer;

    localparam logic [1:0] S_EXP = 2'd0, S_LOW = 2'd1, S_HIGH = 2'd2;
    localparam logic [7:0] M_TICK = 8'h01, M_D = 8'h02, M_R = 8'h04, M_L = 8'h08;
    localparam logic [7:0] M_U = 8'h10, M_PA = 8'h20, M_PB = 8'h40, M_HT = 8'h80;

    logic       CLK = 1'b0;
    logic       RESET_N, TICK, HALF_TICK, BTN_U, BTN_L, BTN_R, BTN_D, PRE_A, PRE_B;
    logic [3:0] DIG0, DIG1, DIG2, DIG3;
    logic       DISP_ON;
    logic [1:0] STATE;
`ifdef METER_ALARM_EN
    logic       ALARM;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [18:0] exp_q[$];
    logic [15:0] shown_dig;
    int          k;

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    meter_sequencer dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .TICK      (TICK),
        .HALF_TICK (HALF_TICK),
        .BTN_U     (BTN_U),
        .BTN_L     (BTN_L),
        .BTN_R     (BTN_R),
        .BTN_D     (BTN_D),
        .PRE_A     (PRE_A),
        .PRE_B     (PRE_B),
        .DIG0      (DIG0),
        .DIG1      (DIG1),
        .DIG2      (DIG2),
        .DIG3      (DIG3),
        .DISP_ON   (DISP_ON),
`ifdef METER_ALARM_EN
        .ALARM     (ALARM),
`endif
        .STATE     (STATE)
    );

    function automatic logic [15:0] bcd_of(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] dig_now();
        return {DIG3, DIG2, DIG1, DIG0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse(input logic [7:0] m);
        {HALF_TICK, PRE_B, PRE_A, BTN_U, BTN_L, BTN_R, BTN_D, TICK} = m;
        cyc(1);
        {HALF_TICK, PRE_B, PRE_A, BTN_U, BTN_L, BTN_R, BTN_D, TICK} = '0;
    endtask

    // scoreboard
    task automatic expect_settled(input int count, input logic [1:0] st, input logic disp);
        exp_q.push_back({st, disp, bcd_of(count)});
    endtask

    task automatic settle(input string tag, input int cycles);
        logic [18:0] e;
        int          bad;
        bad = 0;
        e = exp_q.pop_front();
        for (int i = 0; i < cycles; i++) begin
            cyc(1);
            if (dig_now() !== shown_dig && dig_now() !== e[15:0]) bad++;
        end
        chk({tag, "_glitch"}, bad, 0);
        chk({tag, "_dig"}, dig_now(), e[15:0]);
        chk({tag, "_state"}, STATE, e[18:17]);
        chk({tag, "_disp"}, DISP_ON, e[16]);
        shown_dig = e[15:0];
    endtask

    initial begin
        RESET_N = 1'b0;
        {HALF_TICK, PRE_B, PRE_A, BTN_U, BTN_L, BTN_R, BTN_D, TICK} = '0;
        shown_dig = 16'h0000;
        cyc(3);
        chk("rst_dig", dig_now(), 16'h0000);
        chk("rst_state", STATE, S_EXP);
        chk("rst_disp", DISP_ON, 1);
`ifdef METER_ALARM_EN
        chk("rst_alarm", ALARM, 0);
`endif
        RESET_N = 1'b1;
        cyc(2);

        pulse(M_U);                  expect_settled(60, S_LOW, 1);   settle("add_u", 17);
        pulse(M_L | M_R | M_D);      expect_settled(180, S_LOW, 1);  settle("btn_prio", 17);
        pulse(M_PB | M_PA | M_U | M_TICK); expect_settled(205, S_HIGH, 1); settle("pre_prio", 17);
        repeat (6) pulse(M_TICK);    expect_settled(199, S_LOW, 0);  settle("tick6", 17);

        // 199 -> 198: display enable follows one cycle after the count
        pulse(M_TICK);
        chk("disp_lat0", DISP_ON, 0);
        cyc(1);
        chk("disp_lat1", DISP_ON, 1);
        expect_settled(198, S_LOW, 1); settle("tick1", 16);

        // add and tick together: 505 then pending tick gives 504 one cycle later
        pulse(M_PB);                 expect_settled(205, S_HIGH, 1); settle("pre_b", 17);
        pulse(M_D | M_TICK);
        cyc(16);
        chk("pend_before", dig_now(), 16'h0205);
        cyc(1);
        chk("pend_applied", dig_now(), 16'h0504);
        chk("pend_state", STATE, S_HIGH);
        shown_dig = 16'h0504;

        repeat (31) pulse(M_D);
        repeat (4) pulse(M_TICK);    expect_settled(9800, S_HIGH, 1); settle("big", 17);
        pulse(M_D);                  expect_settled(9999, S_HIGH, 1); settle("sat", 17);
        pulse(M_U);                  expect_settled(9999, S_HIGH, 1); settle("sat_hold", 17);

        // leave blink phase at 0 so the forced-1 on expiry is visible
        pulse(M_HT);
        pulse(M_PA);
        repeat (9) pulse(M_TICK);    expect_settled(1, S_LOW, 0);    settle("one", 17);
        pulse(M_TICK);
`ifdef METER_ALARM_EN
        chk("alarm_hi", ALARM, 1);
`endif
        cyc(1);
`ifdef METER_ALARM_EN
        chk("alarm_lo", ALARM, 0);
`endif
        chk("exp_state", STATE, S_EXP);
        chk("exp_entry_disp", DISP_ON, 1);
        k = $urandom_range(1, 5);
        for (int i = 0; i < k; i++) begin
            pulse(M_HT);
            chk("blink", DISP_ON, (i % 2 == 0) ? 0 : 1);
        end
        repeat (3) pulse(M_TICK);
`ifdef METER_ALARM_EN
        chk("alarm_idle", ALARM, 0);
`endif
        expect_settled(0, S_EXP, (k % 2 == 0) ? 1'b1 : 1'b0); settle("expired", 17);

        // tick in the preset cycle must not leave a pending decrement
        pulse(M_PB | M_TICK);        expect_settled(205, S_HIGH, 1); settle("pre_tick", 17);

        // count change mid-conversion: only the final value may appear
        pulse(M_PA);
        cyc(2);
        pulse(M_L);                  expect_settled(130, S_LOW, 1);  settle("abort", 18);

        // asynchronous reset in the middle of a conversion
        pulse(M_TICK);
        cyc(4);
        chk("pre_arst_state", STATE, S_LOW);
        chk("pre_arst_disp", DISP_ON, 0);
        RESET_N = 1'b0;
        #1;
        chk("arst_dig", dig_now(), 16'h0000);
        chk("arst_state", STATE, S_EXP);
        chk("arst_disp", DISP_ON, 1);
        cyc(2);
        RESET_N = 1'b1;
        shown_dig = 16'h0000;
        cyc(1);
        pulse(M_U);                  expect_settled(60, S_LOW, 1);   settle("post_rst", 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/meter_sequencer.md
# meter_sequencer

Time-keeping controller for the parking meter. It arbitrates single-cycle button, preset and 1 Hz tick events onto one 14-bit remaining-time register, and tracks the meter state (expired / low / high). It drives four BCD digits through a multi-cycle binary-to-BCD converter and generates the display blink enable. It sits between the debounced/synchronised button pulses and the hex-to-7-segment/display-mux path.

## Interface
- `MAX_COUNT`, 9999: saturation ceiling (seconds)
- `ADD_U` / `ADD_L` / `ADD_R` / `ADD_D`, 60 / 120 / 180 / 300: seconds added per button
- `PRESET_A` / `PRESET_B`, 10 / 205: preset load values
- `LOW_THRESH`, 200: counts below this (and >0) are LOW
- `CLK`  in  1  system clock
- `RESET_N`  in  1  asynchronous, active-low reset
- `TICK`  in  1  1 Hz single-cycle pulse (count down)
- `HALF_TICK`  in  1  2 Hz single-cycle pulse (expired blink)
- `BTN_U`, `BTN_L`, `BTN_R`, `BTN_D`  in  1 each  single-cycle add requests
- `PRE_A`, `PRE_B`  in  1 each  single-cycle preset requests
- `DIG0..DIG3`  out  4 each  BCD digits, DIG0 = ones
- `DISP_ON`  out  1  display enable (blink)
- `STATE`  out  2  0 EXPIRED, 1 LOW, 2 HIGH
- `ALARM`  out  1  expiry pulse (only with `METER_ALARM_EN`)

## Operation
- Reset values: count 0, STATE EXPIRED, DIG0..3 = 0, DISP_ON 1, blink phase 1, tick-pending 0, converter idle, ALARM 0.
- At most one count update per cycle. Fixed priority: PRE_B > PRE_A > BTN_U > BTN_L > BTN_R > BTN_D > tick.
- Lower-priority button or preset pulses in the same cycle are dropped.
- A TICK that loses arbitration sets tick-pending. The pending decrement is applied on the next cycle with no button/preset event.
- A preset clears tick-pending, and so does a TICK landing in the same cycle as the preset.
- Add: count = min(count + ADD_x, MAX_COUNT). Use 15-bit intermediate; no wrap.
- Preset: count = PRESET_x, regardless of current value.
- Tick: count − 1 if count > 0. Ticks (and pending ticks) at count 0 are discarded; count never underflows.
- STATE is decoded from the registered count: 0 → EXPIRED, 1..LOW_THRESH−1 → LOW, ≥ LOW_THRESH → HIGH.
- DISP_ON:
  - HIGH → 1
  - LOW → ~count[0] (on for even seconds)
  - EXPIRED → blink phase, toggled on each HALF_TICK; phase forced to 1 on entry to EXPIRED
- Converter FSM IDLE → SHIFT (14 cycles, double-dabble) → LOAD → IDLE. It starts on every count change.
- A count change during SHIFT aborts the conversion and restarts it on the next cycle. DIG0..3 hold the last completed result.

## Timing
- Count register updates on the clock edge following the event (1-cycle latency).
- STATE and DISP_ON follow the registered count combinationally-decoded then registered: +1 cycle.
- DIG0..3 are valid 16 cycles after the count register changes, if there are no further changes.
- Pending tick: applied ≥1 cycle after the blocking event.
- Async reset takes effect immediately mid-conversion; release is synchronous to CLK.

## Configuration
- `METER_ALARM_EN` defined:
  - ALARM pulses high for exactly one cycle when count transitions 1 → 0 via tick.
  - A preset/add in the same cycle suppresses the transition and therefore the pulse.
- Undefined: the ALARM port and its logic are absent.

## Structure
- Shared package `meter_pkg`:
  - state enum (EXPIRED/LOW/HIGH)
  - converter state enum
  - COUNT_W = 14
  - BCD digit type
- One sub-module: `bin2bcd_seq`, a sequential double-dabble converter with start/busy/done handshake. Arbitration, count and blink logic stay in the top.

## Test plan
- Reset, then BTN_U → count 60, STATE HIGH? No, 60 < 200 → STATE LOW; DIG = 0,0,6,0 after 16 cycles; DISP_ON 1 (even).
- PRE_B then 6 TICKs → count 199, STATE LOW, DISP_ON 0 (odd count).
- BTN_D and TICK in the same cycle at count 205 → cycle+1 count 505, cycle+2 count 504 (pending tick applied).
- Count 9800, BTN_D → count 9999 (saturated); DIG = 9,9,9,9.
- Count 1, TICK → count 0, STATE EXPIRED, DISP_ON toggles on each HALF_TICK; ALARM one-cycle pulse with `METER_ALARM_EN`. Further TICKs leave the count at 0.
- PRE_A then BTN_L 3 cycles later (mid-conversion) → DIG ends at 1,3,0 (130) and is never left showing a partial value; assert RESET_N low mid-SHIFT → all outputs return to reset values immediately.
